// File: rtl/score_input_conditioner_pkg.sv
// Shared types and constants for the score input conditioner: FSM state
// encoding, channel indices and the score priority resolver.
package score_input_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int NUM_CHANNELS            = 5;

  localparam int CH_ONE   = 0;
  localparam int CH_TWO   = 1;
  localparam int CH_THREE = 2;
  localparam int CH_PAUSE = 3;
  localparam int CH_TEAM  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIRE = 2'b01,
    HOLD = 2'b10
  } score_state_e;

  // One-hot event from simultaneous score edges; higher point value wins.
  function automatic logic [2:0] score_priority(input logic [2:0] rise);
    logic [2:0] sel;
    if (rise[2]) begin
      sel = 3'b100;
    end else if (rise[1]) begin
      sel = 3'b010;
    end else if (rise[0]) begin
      sel = 3'b001;
    end else begin
      sel = 3'b000;
    end
    return sel;
  endfunction

endpackage

// File: rtl/score_input_conditioner_if.sv
// Button/switch inputs and conditioned score/pause/team outputs of the
// scoreboard front end, bundled as one interface.
interface score_input_conditioner_if;

  logic btn_one;
  logic btn_two;
  logic btn_three;
  logic btn_pause;
  logic sw_team;

  logic one_point;
  logic two_point;
  logic three_point;
  logic team;
  logic pause;

  modport master (
    output btn_one, btn_two, btn_three, btn_pause, sw_team,
    input  one_point, two_point, three_point, team, pause
  );

  modport slave (
    input  btn_one, btn_two, btn_three, btn_pause, sw_team,
    output one_point, two_point, three_point, team, pause
  );

endinterface

// File: rtl/score_input_conditioner_debounce_cell.sv
// One input channel: SYNC_STAGES-deep synchronizer followed by a saturating
// stability counter that moves the debounced level.
module debounce_cell
  import score_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          count_r;
  logic                   level_r;
  logic                   synced_s;

  assign synced_s = sync_r[SYNC_STAGES-1];
  assign level    = level_r;

  // Synchronizer shift chain for the asynchronous raw input.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // Level flips on the last of DEBOUNCE_CYCLES disagreeing cycles, so the
  // counter tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      level_r <= 1'b0;
    end else if (synced_s != level_r) begin
      if (count_r == CNT_LAST) begin
        count_r <= '0;
        level_r <= synced_s;
      end else begin
        count_r <= count_r + CW'(1);
        level_r <= level_r;
      end
    end else begin
      count_r <= '0;
      level_r <= level_r;
    end
  end

endmodule

// File: rtl/score_input_conditioner.sv
// Scoreboard input front end: five debounced channels, a one-shot score FSM
// with three>two>one priority, a team-select level and a pause toggle.
module score_input_conditioner
  import score_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  score_input_conditioner_if.slave    bus
);

  logic [NUM_CHANNELS-1:0] raw_s;
  logic [NUM_CHANNELS-1:0] level_s;
  logic [2:0]              score_level_s;
  logic [2:0]              prev_r;
  logic [2:0]              rise_r;
  logic                    pause_prev_r;
  logic                    pause_r;
  logic                    team_r;
  logic [2:0]              fire_r;
  score_state_e            state_r;

  assign raw_s = {bus.sw_team, bus.btn_pause, bus.btn_three, bus.btn_two, bus.btn_one};

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .raw   (raw_s[i]),
      .level (level_s[i])
    );
  end

  assign score_level_s = level_s[CH_THREE:CH_ONE];

  // Registered rising-edge detect on score levels; pause toggles directly
  // on its edge so it lands one cycle after the debounced rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_r       <= 3'b000;
      rise_r       <= 3'b000;
      pause_prev_r <= 1'b0;
      pause_r      <= 1'b0;
    end else begin
      prev_r       <= score_level_s;
      rise_r       <= score_level_s & ~prev_r;
      pause_prev_r <= level_s[CH_PAUSE];
      if (level_s[CH_PAUSE] && !pause_prev_r) begin
        pause_r <= ~pause_r;
      end else begin
        pause_r <= pause_r;
      end
    end
  end

  // Score FSM with registered one-hot event and team outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      fire_r  <= 3'b000;
      team_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          team_r <= level_s[CH_TEAM];
          if (|rise_r) begin
            state_r <= FIRE;
            fire_r  <= score_priority(rise_r);
          end else begin
            state_r <= IDLE;
            fire_r  <= 3'b000;
          end
        end
        FIRE: begin
          state_r <= HOLD;
          fire_r  <= 3'b000;
          team_r  <= team_r;
        end
        HOLD: begin
          fire_r <= 3'b000;
          team_r <= level_s[CH_TEAM];
          if (score_level_s == 3'b000) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
          fire_r  <= 3'b000;
          team_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.one_point   = fire_r[0];
  assign bus.two_point   = fire_r[1];
  assign bus.three_point = fire_r[2];
  assign bus.team        = team_r;
  assign bus.pause       = pause_r;

endmodule

// File: tb/tb_score_input_conditioner.sv
// Directed bench for score_input_conditioner with DEBOUNCE_CYCLES=4 and
// SYNC_STAGES=2: a raw press shows up as a score pulse 8 edges later.
module tb_score_input_conditioner;
  import score_input_conditioner_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cnt_one;
  int   cnt_two;
  int   cnt_three;
  int   multi;

  score_input_conditioner_if bus ();

  score_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse tally sampled mid-cycle, plus a one-hot watchdog.
  always @(negedge clock) begin
    if (bus.one_point === 1'b1)   cnt_one++;
    if (bus.two_point === 1'b1)   cnt_two++;
    if (bus.three_point === 1'b1) cnt_three++;
    if ($countones({bus.one_point, bus.two_point, bus.three_point}) > 1) multi++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int b_one;
    int b_two;
    int b_three;
    checks = 0; errors = 0;
    cnt_one = 0; cnt_two = 0; cnt_three = 0; multi = 0;
    reset = 1'b0;
    bus.btn_one = 1'b0; bus.btn_two = 1'b0; bus.btn_three = 1'b0;
    bus.btn_pause = 1'b0; bus.sw_team = 1'b0;

    step(3);
    check("rst_one", 32'(bus.one_point), 32'd0);
    check("rst_two", 32'(bus.two_point), 32'd0);
    check("rst_three", 32'(bus.three_point), 32'd0);
    check("rst_team", 32'(bus.team), 32'd0);
    check("rst_pause", 32'(bus.pause), 32'd0);
    reset = 1'b1;
    step(5);

    // btn_two held 20 cycles: single pulse exactly 8 edges after the raw rise.
    b_two = cnt_two;
    bus.btn_two = 1'b1;
    step(7);
    check("two_early", 32'(bus.two_point), 32'd0);
    step(1);
    check("two_fire", 32'(bus.two_point), 32'd1);
    check("two_team", 32'(bus.team), 32'd0);
    step(1);
    check("two_end", 32'(bus.two_point), 32'd0);
    step(11);
    bus.btn_two = 1'b0;
    step(12);
    check("two_count", 32'(cnt_two - b_two), 32'd1);

    // Glitching btn_one never stays high long enough.
    b_one = cnt_one;
    for (int k = 0; k < 4; k++) begin
      bus.btn_one = 1'b1;
      step(3);
      bus.btn_one = 1'b0;
      step(1);
    end
    step(12);
    check("glitch_one", 32'(cnt_one - b_one), 32'd0);

    // Team switch on, then btn_one and btn_three together: only three fires.
    bus.sw_team = 1'b1;
    step(10);
    check("team_level", 32'(bus.team), 32'd1);
    b_one = cnt_one; b_three = cnt_three;
    bus.btn_one = 1'b1; bus.btn_three = 1'b1;
    step(8);
    check("pri_three", 32'(bus.three_point), 32'd1);
    check("pri_one_low", 32'(bus.one_point), 32'd0);
    check("pri_team", 32'(bus.team), 32'd1);
    step(4);
    bus.btn_three = 1'b0;
    step(6);
    bus.btn_one = 1'b0;
    step(12);
    check("pri_three_cnt", 32'(cnt_three - b_three), 32'd1);
    check("pri_one_cnt", 32'(cnt_one - b_one), 32'd0);

    // btn_one pressed while two is held is ignored until full release.
    b_one = cnt_one; b_two = cnt_two;
    bus.btn_two = 1'b1;
    step(8);
    check("hold_two", 32'(bus.two_point), 32'd1);
    step(3);
    bus.btn_one = 1'b1;
    step(10);
    bus.btn_one = 1'b0; bus.btn_two = 1'b0;
    step(12);
    check("hold_two_cnt", 32'(cnt_two - b_two), 32'd1);
    check("hold_one_cnt", 32'(cnt_one - b_one), 32'd0);
    bus.btn_one = 1'b1;
    step(8);
    check("after_one", 32'(bus.one_point), 32'd1);
    step(1);
    check("after_one_end", 32'(bus.one_point), 32'd0);
    bus.btn_one = 1'b0;
    step(10);
    check("after_one_cnt", 32'(cnt_one - b_one), 32'd1);

    // Three pause presses give 1, 0, 1; toggle lands 7 edges after the press.
    for (int p = 0; p < 3; p++) begin
      bus.btn_pause = 1'b1;
      step(6);
      check("pause_before", 32'(bus.pause), 32'(p % 2));
      step(1);
      check("pause_after", 32'(bus.pause), 32'((p + 1) % 2));
      step(3);
      bus.btn_pause = 1'b0;
      step(10);
      check("pause_release", 32'(bus.pause), 32'((p + 1) % 2));
    end

    // Reset during the three_point FIRE cycle aborts it; held button refires.
    bus.btn_three = 1'b1;
    step(8);
    check("rf_fire", 32'(bus.three_point), 32'd1);
    reset = 1'b0;
    #1;
    check("rf_abort", 32'(bus.three_point), 32'd0);
    check("rf_idle", 32'(dut.state_r), 32'(IDLE));
    check("rf_pause", 32'(bus.pause), 32'd0);
    check("rf_team", 32'(bus.team), 32'd0);
    b_three = cnt_three;
    step(3);
    check("rf_hold", 32'(bus.three_point), 32'd0);
    reset = 1'b1;
    step(7);
    check("rf_early", 32'(bus.three_point), 32'd0);
    step(1);
    check("rf_refire", 32'(bus.three_point), 32'd1);
    step(1);
    check("rf_refire_end", 32'(bus.three_point), 32'd0);
    bus.btn_three = 1'b0;
    step(15);
    check("rf_cnt", 32'(cnt_three - b_three), 32'd1);
    check("onehot", 32'(multi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_input_conditioner.md
SCORE_INPUT_CONDITIONER -- requirements
Module: score_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, means consecutive stable cycles before a debounced level changes (10 ms at 100 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, means flip-flop depth of each input synchronizer.
REQ-003 clock  input  1  100 MHz system clock; the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_one  input  1  raw, asynchronous 1-point push button.
REQ-006 btn_two  input  1  raw 2-point push button.
REQ-007 btn_three  input  1  raw 3-point push button.
REQ-008 btn_pause  input  1  raw pause push button.
REQ-009 sw_team  input  1  raw team-select slide switch.
REQ-010 one_point  output  1  single-cycle 1-point event.
REQ-011 two_point  output  1  single-cycle 2-point event.
REQ-012 three_point  output  1  single-cycle 3-point event.
REQ-013 team  output  1  debounced team select, sampled with each score event.
REQ-014 pause  output  1  pause level; toggles once per debounced btn_pause press.

Function
REQ-015 Each raw input SHALL pass through a SYNC_STAGES-deep synchronizer before any other use.
REQ-016 Each debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears that channel's counter.
REQ-017 Debounce counters SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide and SHALL never wrap.
REQ-018 Score FSM SHALL have states IDLE, FIRE and HOLD.
REQ-019 In IDLE, a rising edge on any debounced score button SHALL latch the event and move to FIRE.
REQ-020 Simultaneous score rising edges SHALL resolve by priority three > two > one, producing exactly one event.
REQ-021 FIRE SHALL last exactly one cycle, asserting the latched score output, then move to HOLD.
REQ-022 HOLD SHALL persist until all three debounced score buttons are low, then return to IDLE; score edges seen in HOLD SHALL be ignored.
REQ-023 At most one of one_point/two_point/three_point SHALL be high in any cycle.
REQ-024 Score outputs SHALL be registered, asserting two cycles after the debounced rising edge (edge detect, then FIRE).
REQ-025 team SHALL be the debounced sw_team level, and SHALL be held constant during the FIRE cycle.
REQ-026 pause SHALL toggle one cycle after each debounced btn_pause rising edge, independently of the score FSM.

Reset
REQ-027 Reset assertion SHALL immediately clear all synchronizers, debounced levels and counters, and force the FSM to IDLE.
REQ-028 During reset, one_point, two_point, three_point, team and pause SHALL all be 0.
REQ-029 A button held through reset release SHALL be treated as a new press and fire once after debounce.
REQ-030 Reset asserted during FIRE SHALL abort the event with no pulse, after reset or in any later cycle.

Structure
REQ-031 The shared package SHALL hold the FSM state enum and the DEBOUNCE_CYCLES default constant.
REQ-032 Each channel SHALL instantiate one sub-module, debounce_cell (synchronizer plus counter plus debounced level); there SHALL be five instances.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-033 btn_two held high 20 cycles -> two_point high for exactly 1 cycle, 8 cycles after the raw rise; no further pulse.
REQ-034 btn_one glitching high 3 cycles, low 1 cycle, repeated -> no score pulse at all.
REQ-035 btn_one and btn_three rise together -> only three_point pulses; btn_one released later -> no one_point.
REQ-036 btn_two held, btn_one pressed while held, both released, then btn_one pressed -> two_point, then exactly one one_point only after full release.
REQ-037 btn_pause pressed and released 3 times -> pause sequence 1,0,1.
REQ-038 reset asserted in the FIRE cycle of btn_three -> three_point stays 0 and the FSM is IDLE; btn_three still held at release -> one three_point after debounce.
